// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer/size codes and command-master FSM states
package ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;
  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
endpackage

// File: rtl/ahb_wait_timer.sv
// ahb_wait_timer: counts consecutive HREADY-low data-phase cycles and flags expiry
// Ports: HCLK, HRESETn (async active-low), en (in data phase), hready, expired (limit reached this cycle)
module ahb_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic en,
  input  logic hready,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cnt <= '0;
    else cnt <= (en && !hready) ? cnt + 1'b1 : '0;
  assign expired = en && !hready && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: single-transfer AHB-Lite manager driven by a valid/ready command port
// Ports: HCLK, HRESETn (async active-low); cmd_valid/cmd_ready/cmd_write/cmd_size/cmd_addr/cmd_wdata in;
//        rsp_valid/rsp_rdata/rsp_err/rsp_timeout out; HADDR/HWRITE/HSIZE/HTRANS/HWDATA out; HREADY/HRDATA/HRESP in.
// Option: define AHB_MST_TIMEOUT_EN to abort a data phase after TIMEOUT_CYCLES consecutive wait states.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);
  state_t state, state_n;
  logic accept, legal, done, expired;
  assign accept = cmd_valid && cmd_ready;
  assign legal = cmd_size == HSIZE_BYTE
              || (cmd_size == HSIZE_HALF && !cmd_addr[0])
              || (cmd_size == HSIZE_WORD && cmd_addr[1:0] == 2'b00);
  assign done = state == S_DATA && HREADY;
`ifdef AHB_MST_TIMEOUT_EN
  ahb_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .en      (state == S_DATA),
    .hready  (HREADY),
    .expired (expired)
  );
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) rsp_timeout <= 1'b0;
    else rsp_timeout <= expired;
`else
  assign expired = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cmd_ready = state == S_IDLE;
    HTRANS = state == S_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
    if (accept && legal) state_n = S_ADDR;
    else if (state == S_ADDR && HREADY) state_n = S_DATA;
    else if (done || expired) state_n = S_IDLE;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= S_IDLE;
      HADDR <= '0;
      HWRITE <= 1'b0;
      HSIZE <= '0;
      HWDATA <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        HADDR <= cmd_addr;
        HWRITE <= cmd_write;
        HSIZE <= cmd_size;
        HWDATA <= cmd_wdata;
      end
      rsp_valid <= (accept && !legal) || done || expired;
      rsp_err <= (accept && !legal) || (done && HRESP) || expired;
      if (done && !HWRITE) rsp_rdata <= HRDATA;
    end
endmodule
